// File: rtl/program_buffer_pkg.sv
// Shared types and constants for the program buffer.
`default_nettype none

package program_buffer_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic MODE_SHIFT  = 1'b0;
   localparam logic MODE_DIRECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/program_buffer.sv
// Instruction buffer with shift-append / direct-write loading, per-entry valid
// bits, a one-entry-per-cycle clear sweep and a registered read port.
`default_nettype none

module program_buffer
   import program_buffer_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             load_mode,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_hit,
   output logic [AW:0]      count,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] vld_next;
   state_t           state;
   state_t           state_next;
   logic [AW-1:0]    ptr;
   logic [AW-1:0]    ptr_next;
   logic             accept;
   logic             rd_take;

   function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (v[i]) n = n + (AW+1)'(1);
      end
      return n;
   endfunction

   assign load_ready = (state == READY) && !clear;
   assign accept     = load_valid && load_ready;
   assign rd_take    = rd_en && (state == READY) && !clear;
   assign full       = (count == (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         ptr   <= '0;
         vld   <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         vld   <= vld_next;
         count <= popcount(vld_next);
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      vld_next   = vld;
      if (clear) begin
         state_next = CLEAR;
         ptr_next   = '0;
         vld_next   = '0;
      end else if (state == CLEAR) begin
         ptr_next = ptr + AW'(1);
         if (ptr == AW'(DEPTH - 1)) state_next = READY;
      end else if (accept) begin
         if (load_mode == MODE_SHIFT) vld_next = {1'b1, vld[DEPTH-1:1]};
         else                         vld_next[load_addr] = 1'b1;
      end
   end

   // Read samples pre-edge contents, so a same-cycle load is not visible yet.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_hit   <= 1'b0;
      end else begin
         rd_valid <= rd_take;
         if (rd_take) begin
            rd_data <= mem[rd_addr];
            rd_hit  <= vld[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !clear) begin
         if (state == CLEAR) begin
            mem[ptr] <= '0;
         end else if (accept) begin
            if (load_mode == MODE_SHIFT) begin
               for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
               mem[DEPTH-1] <= load_data;
            end else begin
               mem[load_addr] <= load_data;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_program_buffer.sv
// Directed self-checking bench for program_buffer.
`default_nettype none

module tb_program_buffer;

   localparam int WIDTH = 12;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             load_valid;
   logic             load_ready;
   logic             load_mode;
   logic [AW-1:0]    load_addr;
   logic [WIDTH-1:0] load_data;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_hit;
   logic [AW:0]      count;
   logic             full;

   int vectors     = 0;
   int miscompares = 0;

   program_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_mode  (load_mode),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_hit     (rd_hit),
      .count      (count),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_mode = 1'b0;
      load_addr = '0; load_data = '0; rd_en = 1'b0; rd_addr = '0;

      // Reset state
      step();
      chk("rst_ready", 32'(load_ready), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_rdd", 32'(rd_data), 0);
      chk("rst_hit", 32'(rd_hit), 0);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("init_sweep%0d", i), 32'(load_ready), 0);
         step();
      end
      chk("init_ready", 32'(load_ready), 1);
      chk("init_count", 32'(count), 0);
      chk("init_full", 32'(full), 0);

      // Shift-append 0x101..0x10A
      load_valid = 1'b1; load_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         load_data = 12'h101 + 12'(i);
         step();
      end
      load_valid = 1'b0;
      chk("shift_count", 32'(count), 8);
      chk("shift_full", 32'(full), 1);
      rd_en = 1'b1; rd_addr = 3'd0;
      step();
      chk("shift_rd0_v", 32'(rd_valid), 1);
      chk("shift_rd0_d", 32'(rd_data), 32'h103);
      chk("shift_rd0_h", 32'(rd_hit), 1);
      rd_addr = 3'd7;
      step();
      chk("shift_rd7_d", 32'(rd_data), 32'h10A);
      chk("shift_rd7_h", 32'(rd_hit), 1);
      rd_en = 1'b0;
      step();
      chk("rd_idle_v", 32'(rd_valid), 0);
      chk("rd_idle_hold", 32'(rd_data), 32'h10A);

      // Clear, then direct write
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_count", 32'(count), 0);
      chk("clr_full", 32'(full), 0);
      for (int i = 0; i < DEPTH; i++) step();
      chk("clr_ready", 32'(load_ready), 1);
      load_valid = 1'b1; load_mode = 1'b1; load_addr = 3'd5; load_data = 12'hABC;
      step();
      load_valid = 1'b0;
      chk("dir_count", 32'(count), 1);
      rd_en = 1'b1; rd_addr = 3'd5;
      step();
      chk("dir_rd5_d", 32'(rd_data), 32'hABC);
      chk("dir_rd5_h", 32'(rd_hit), 1);
      rd_addr = 3'd2;
      step();
      chk("dir_rd2_d", 32'(rd_data), 0);
      chk("dir_rd2_h", 32'(rd_hit), 0);
      rd_en = 1'b0;

      // Read-before-write on the same entry
      load_valid = 1'b1; load_addr = 3'd3; load_data = 12'h111;
      step();
      chk("rbw_count1", 32'(count), 2);
      load_data = 12'h777; rd_en = 1'b1; rd_addr = 3'd3;
      step();
      load_valid = 1'b0;
      chk("rbw_old", 32'(rd_data), 32'h111);
      chk("rbw_old_h", 32'(rd_hit), 1);
      step();
      chk("rbw_new", 32'(rd_data), 32'h777);
      chk("rbw_count2", 32'(count), 2);

      // Clear with pending load: load dropped, reads ignored during sweep
      rd_en = 1'b1; rd_addr = 3'd3;
      load_valid = 1'b1; load_mode = 1'b1; load_addr = 3'd0; load_data = 12'h555;
      clear = 1'b1;
      #1;
      chk("clr_ld_ready", 32'(load_ready), 0);
      step();
      clear = 1'b0; load_valid = 1'b0;
      chk("clr_ld_count", 32'(count), 0);
      chk("clr_ld_rdv", 32'(rd_valid), 0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         chk($sformatf("clr_sweep%0d", i), 32'(load_ready), 0);
         step();
      end
      chk("clr_sweep7", 32'(load_ready), 0);
      chk("clr_rd_ign_v", 32'(rd_valid), 0);
      chk("clr_rd_hold", 32'(rd_data), 32'h777);
      step();
      chk("clr_ld_ready2", 32'(load_ready), 1);
      rd_addr = 3'd0;
      step();
      chk("drop_rd0_v", 32'(rd_valid), 1);
      chk("drop_rd0_d", 32'(rd_data), 0);
      chk("drop_rd0_h", 32'(rd_hit), 0);
      rd_en = 1'b0;

      // Sweep restarts: reset at ptr=4, then clear at ptr=6
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_ready", 32'(load_ready), 0);
      for (int i = 0; i < 6; i++) step();
      chk("mid_pre_clr", 32'(load_ready), 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) step();
      chk("restart_low", 32'(load_ready), 0);
      step();
      chk("restart_high", 32'(load_ready), 1);
      rd_en = 1'b1; rd_addr = 3'd5;
      step();
      rd_en = 1'b0;
      chk("restart_rd5_d", 32'(rd_data), 0);
      chk("restart_rd5_h", 32'(rd_hit), 0);
      chk("restart_count", 32'(count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
